// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence blocks: colour codes, playback
// states, default memory geometry and the colour-to-LED decode.
package simon_pkg;

  localparam int unsigned SIMON_DEPTH = 10;
  localparam int unsigned SIMON_AW    = 4;
  localparam int unsigned SIMON_DW    = 2;
  localparam int unsigned SIMON_LEDW  = 2 ** SIMON_DW;

  localparam logic [SIMON_DW-1:0] GREEN  = 2'd0;
  localparam logic [SIMON_DW-1:0] RED    = 2'd1;
  localparam logic [SIMON_DW-1:0] YELLOW = 2'd2;
  localparam logic [SIMON_DW-1:0] BLUE   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SHOW,
    ST_GAP,
    ST_FIN
  } state_t;

  function automatic logic [SIMON_LEDW-1:0] color_onehot(input logic [SIMON_DW-1:0] c);
    logic [SIMON_LEDW-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sequence_ram.sv
// Simon sequence memory: one write port for the recorder, one synchronous
// read port (1-cycle latency) for the player.
module sequence_ram
  import simon_pkg::*;
#(
  parameter int unsigned AW = SIMON_AW,
  parameter int unsigned DW = SIMON_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sequence_player.sv
// Plays back the stored Simon sequence: fetches each colour from the RAM,
// lights it for ON_CYCLES, blanks for OFF_CYCLES, then pulses done.
module sequence_player
  import simon_pkg::*;
#(
  parameter int unsigned DEPTH      = SIMON_DEPTH,
  parameter int unsigned AW         = SIMON_AW,
  parameter int unsigned DW         = SIMON_DW,
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned OFF_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [AW-1:0]    seq_len,
  output logic [AW-1:0]    rd_addr,
  input  logic [DW-1:0]    rd_data,
  output logic [2**DW-1:0] led,
  output logic [DW-1:0]    color,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LEDW = 2 ** DW;
  localparam int unsigned MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);

  state_t        state;
  logic [TW-1:0] timer;
  logic [AW-1:0] idx;
  logic [AW-1:0] len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      timer   <= '0;
      idx     <= '0;
      len     <= '0;
      rd_addr <= '0;
      led     <= '0;
      color   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort outranks every transition, including the one into FIN
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        led   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              busy <= 1'b1;
              if (seq_len == '0) begin
                state <= ST_FIN;
                done  <= 1'b1;
              end else begin
                len     <= (seq_len > DEPTH_A) ? DEPTH_A : seq_len;
                rd_addr <= '0;
                idx     <= '0;
                state   <= ST_FETCH;
              end
            end
          end
          ST_FETCH: state <= ST_LATCH;
          ST_LATCH: begin
            color <= rd_data;
            led   <= LEDW'(color_onehot(SIMON_DW'(rd_data)));
            timer <= '0;
            state <= ST_SHOW;
          end
          ST_SHOW: begin
            if (timer == ON_LAST) begin
              led   <= '0;
              timer <= '0;
              state <= ST_GAP;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_GAP: begin
            if (timer == OFF_LAST) begin
              if (idx == len - AW'(1)) begin
                state <= ST_FIN;
                done  <= 1'b1;
              end else begin
                idx     <= idx + AW'(1);
                rd_addr <= idx + AW'(1);
                state   <= ST_FETCH;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_FIN: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player driving the real sequence RAM.
module tb_sequence_player;

  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 2;
  localparam int unsigned PER = ON + OFF + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] seq_len = '0;
  logic [3:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic [1:0] color;
  logic       busy;
  logic       done;
  logic       we = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [1:0] wr_data = '0;

  typedef struct {
    int         rise;
    logic [1:0] col;
    int         addr;
  } exp_t;

  exp_t       exp_q[$];
  int         done_q[$];
  logic [1:0] model [10];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         abort_cnt = 0;

  always #5 clk = ~clk;

  sequence_ram #(.AW(4), .DW(2)) u_ram (
    .clk(clk), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  sequence_player #(
    .DEPTH(10), .AW(4), .DW(2), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seq_len(seq_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .led(led), .color(color),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start is driven just after an edge and sampled at the next one
  task automatic play(input int n);
    int s;
    int len;
    s = cyc;
    len = (n > 10) ? 10 : n;
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.rise = s + 3 + int'(PER) * i;
      e.col  = model[i];
      e.addr = i;
      exp_q.push_back(e);
    end
    done_q.push_back(s + 1 + int'(PER) * len);
    seq_len = 4'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && i < 400) begin
      tick();
      i++;
    end
    chk("drain_timeout", 32'(exp_q.size() + done_q.size()), 0);
    tick();
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic [3:0] prev_led;
    int         lit_cnt;
    int         abort_seen;
    exp_t       e;
    prev_led = '0;
    lit_cnt = 0;
    abort_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (led != '0) begin
          if (prev_led == '0) begin
            lit_cnt = 1;
            if (exp_q.size() == 0) begin
              chk("unexpected_led", 32'(led), 0);
            end else begin
              e = exp_q.pop_front();
              chk("rise_cycle", cyc, e.rise);
              chk("led", 32'(led), 32'(4'b0001 << e.col));
              chk("color", 32'(color), 32'(e.col));
              chk("rd_addr", 32'(rd_addr), e.addr);
            end
          end else begin
            lit_cnt++;
          end
        end else if (prev_led != '0) begin
          if (abort_seen != abort_cnt) abort_seen = abort_cnt;
          else chk("on_length", lit_cnt, ON);
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            chk("done_cycle", cyc, done_q.pop_front());
            chk("done_leds_empty", 32'(exp_q.size()), 0);
            chk("busy_in_fin", 32'(busy), 1);
          end
        end
      end
      prev_led = led;
    end
  end

  initial begin
    model[0] = 2'd2; model[1] = 2'd0; model[2] = 2'd3; model[3] = 2'd1; model[4] = 2'd1;
    model[5] = 2'd2; model[6] = 2'd0; model[7] = 2'd3; model[8] = 2'd3; model[9] = 2'd1;

    for (int i = 0; i < 10; i++) begin
      tick();
      we = 1'b1;
      wr_addr = 4'(i);
      wr_data = model[i];
    end
    tick();
    we = 1'b0;

    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_led", 32'(led), 0);
    chk("rst_color", 32'(color), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    play(0);
    drain();
    chk("len0_rd_addr", 32'(rd_addr), 0);
    chk("len0_color", 32'(color), 0);

    play(3);
    drain();

    play(15);
    drain();

    play(3);
    repeat (11) tick();
    chk("abort_pre_led", 32'(led), 32'(4'b0001));
    abort_cnt++;
    exp_q.delete();
    done_q.delete();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_led", 32'(led), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_rd_addr", 32'(rd_addr), 1);
    repeat (30) tick();
    chk("abort_idle", 32'(busy), 0);
    play(3);
    drain();

    play(3);
    repeat (5) tick();
    start = 1'b1;
    seq_len = 4'd7;
    tick();
    start = 1'b0;
    repeat (6) tick();
    seq_len = 4'd1;
    drain();

    play(3);
    repeat (14) tick();
    chk("gap_busy", 32'(busy), 1);
    chk("gap_led", 32'(led), 0);
    exp_q.delete();
    done_q.delete();
    rst_n = 1'b0;
    #1;
    chk("async_rd_addr", 32'(rd_addr), 0);
    chk("async_color", 32'(color), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    chk("async_led", 32'(led), 0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_led", 32'(led), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
